universal_barrel_shifter: RTL and testbench

Registered 16-bit universal barrel shifter: logically shifts a data word left or right by 0–15 positions, selected per operation, with zero fill. It is a leaf datapath block for ALU/shift units, implemented as a log2-stage mux network. The result is captured in an output register, with a valid flag tracking each result.

---
 rtl/ubs_pkg.sv | 11 +
 rtl/ubs_stage.sv | 24 ++
 rtl/universal_barrel_shifter.sv | 94 +++++++++
 tb/tb_universal_barrel_shifter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ubs_pkg.sv
// Shared constants for the universal barrel shifter: direction encoding and
// default geometry.
package ubs_pkg;

  localparam int UBS_WIDTH   = 16;
  localparam int UBS_SHIFT_W = $clog2(UBS_WIDTH);

  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

endpackage

// File: rtl/ubs_stage.sv
// One mux stage of the barrel shifter: shifts by a fixed DIST in the chosen
// direction with zero fill when enabled, otherwise passes data through.
module ubs_stage
  import ubs_pkg::*;
#(
  parameter int WIDTH = UBS_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  // Fixed-distance shift select; logical shifts give the zero fill.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      if (dir_i == SHIFT_LEFT) data_o = data_i << DIST;
      else                     data_o = data_i >> DIST;
    end
  end

endmodule

// File: rtl/universal_barrel_shifter.sv
// Registered universal barrel shifter: logical left/right shift by 0..WIDTH-1
// through a log2 cascade of ubs_stage muxes, result and valid registered.
// Optional input register stage: UNIVERSAL_BARREL_SHIFTER_INREG_EN
// (latency 2 when defined, 1 otherwise; results identical).
module universal_barrel_shifter
  import ubs_pkg::*;
#(
  parameter int WIDTH   = UBS_WIDTH,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHIFT_W-1:0] Shift,
  input  logic               ShiftChoice,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  logic [WIDTH-1:0]   a_s;
  logic [SHIFT_W-1:0] sh_s;
  logic               dir_s;
  logic               vld_s;

`ifdef UNIVERSAL_BARREL_SHIFTER_INREG_EN
  logic [WIDTH-1:0]   a_q;
  logic [SHIFT_W-1:0] sh_q;
  logic               dir_q;
  logic               vld_q;

  // Input capture stage; cleared by reset so nothing in flight survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      sh_q  <= '0;
      dir_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= A;
      sh_q  <= Shift;
      dir_q <= ShiftChoice;
      vld_q <= in_valid;
    end
  end

  assign a_s   = a_q;
  assign sh_s  = sh_q;
  assign dir_s = dir_q;
  assign vld_s = vld_q;
`else
  assign a_s   = A;
  assign sh_s  = Shift;
  assign dir_s = ShiftChoice;
  assign vld_s = in_valid;
`endif

  // Stage k shifts by 2^k when Shift[k] is set; direction is shared.
  logic [SHIFT_W:0][WIDTH-1:0] stg;
  assign stg[0] = a_s;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    ubs_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
      .data_i (stg[k]),
      .en_i   (sh_s[k]),
      .dir_i  (dir_s),
      .data_o (stg[k+1])
    );
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_out_q;

  // Result holds its value across idle cycles; only valid ops update it.
  always_comb begin
    out_d = out_q;
    if (vld_s) out_d = stg[SHIFT_W];
  end

  // Output and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      vld_out_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      vld_out_q <= vld_s;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_out_q;

endmodule

// File: tb/tb_universal_barrel_shifter.sv
// Self-checking bench for universal_barrel_shifter: directed cases, async
// reset, and a randomized back-to-back sweep against an arithmetic model.
module tb_universal_barrel_shifter;

`ifdef UNIVERSAL_BARREL_SHIFTER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0;
  logic [3:0]  Shift = '0;
  logic        ShiftChoice = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] out;
  logic        out_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic [15:0] r;
  } ent_t;

  ent_t hist[$];

  universal_barrel_shifter #(.WIDTH(16), .SHIFT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (A),
    .Shift       (Shift),
    .ShiftChoice (ShiftChoice),
    .in_valid    (in_valid),
    .out         (out),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue a single valid op and wait until its result should be visible.
  task automatic op(input logic [15:0] a, input logic [3:0] s, input logic d);
    A = a; Shift = s; ShiftChoice = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a, input int s, input logic d);
    longint unsigned x;
    x = longint'(a);
    if (d) x = (x * (longint'(1) << s)) % 65536;
    else   x = x / (longint'(1) << s);
    return 16'(x);
  endfunction

  initial begin
    logic [15:0] mout;
    int ops;
    int cyc;

    // Reset state, before any clock edge
    #2;
    chk("reset_out", out, 16'h0000);
    chk("reset_vld", {15'd0, out_valid}, 16'h0001 & 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: spec vectors
    op(16'b1011001001010010, 4'd3, 1'b1);
    chk("left3", out, 16'b1001001010010000);
    chk("left3_vld", {15'd0, out_valid}, 16'd1);
    op(16'b1011001001010010, 4'd3, 1'b0);
    chk("right3", out, 16'b0001011001001010);
    chk("right3_vld", {15'd0, out_valid}, 16'd1);
    op(16'hFFFF, 4'd0, 1'b1);
    chk("ffff_l0", out, 16'hFFFF);
    op(16'hFFFF, 4'd0, 1'b0);
    chk("ffff_r0", out, 16'hFFFF);
    op(16'hFFFF, 4'd15, 1'b1);
    chk("ffff_l15", out, 16'h8000);
    op(16'hFFFF, 4'd15, 1'b0);
    chk("ffff_r15", out, 16'h0001);
    op(16'h0001, 4'd15, 1'b1);
    chk("lsb_l15", out, 16'h8000);
    op(16'h8000, 4'd15, 1'b0);
    chk("msb_r15", out, 16'h0001);

    // Valid gating: result must hold while in_valid is low
    op(16'h1234, 4'd0, 1'b1);
    chk("gate_first", out, 16'h1234);
    A = 16'hFFFF; Shift = 4'd4; ShiftChoice = 1'b1; in_valid = 1'b0;
    repeat (LAT) begin @(posedge clk); #1; end
    chk("gate_hold", out, 16'h1234);
    chk("gate_vld", {15'd0, out_valid}, 16'd0);

    // Async reset between edges
    op(16'b1011001001010010, 4'd3, 1'b1);
    chk("pre_rst", out, 16'h9290);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", out, 16'h0000);
    chk("arst_vld", {15'd0, out_valid}, 16'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", out, 16'h0000);
    op(16'hA5C3, 4'd5, 1'b0);
    chk("post_rst_op", out, 16'h052E);
    chk("post_rst_vld", {15'd0, out_valid}, 16'd1);

    // Random back-to-back sweep; inputs were idle before this point
    mout = 16'h052E;
    for (int i = 0; i < LAT - 1; i++) hist.push_back('{v: 1'b0, r: 16'h0});
    ops = 0;
    cyc = 0;
    while (ops < 1000 && cyc < 5000) begin
      ent_t e;
      logic [15:0] a;
      int s;
      logic d, v;
      a = 16'($urandom);
      s = int'($urandom_range(0, 15));
      d = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      A = a; Shift = 4'(s); ShiftChoice = d; in_valid = v;
      e.v = v;
      e.r = model(a, s, d);
      hist.push_back(e);
      if (v) ops++;
      cyc++;
      @(posedge clk); #1;
      e = hist.pop_front();
      if (e.v) mout = e.r;
      chk("rnd_vld", {15'd0, out_valid}, {15'd0, e.v});
      chk("rnd_out", out, mout);
    end
    in_valid = 1'b0;
    tests++;
    assert (ops == 1000) else begin
      fails++;
      $error("FAIL sweep_budget: got %0d ops expected 1000", ops);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
